// File: rtl/lstm_pkg.sv
// Shared types and fixed-point helpers for the sequential LSTM cell.
package lstm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE,
    SER
  } state_t;

  function automatic int one_of(input int frac);
    return 1 << frac;
  endfunction

  function automatic int clamp(input int x, input int lo, input int hi);
    if (x < lo) return lo;
    if (x > hi) return hi;
    return x;
  endfunction

  function automatic int hsig(input int x, input int frac);
    return clamp((x >>> 2) + one_of(frac) / 2, 0, one_of(frac));
  endfunction

  function automatic int htanh(input int x, input int frac);
    return clamp(x, -one_of(frac), one_of(frac));
  endfunction

endpackage

// File: rtl/lstm_elem_unit.sv
// Combinational single-element LSTM datapath.
// LSTM_SAT_EN: saturate the cell-state sum instead of wrapping it.
module lstm_elem_unit #(
  parameter int E = 8,
  parameter int F = 6
) (
  input  logic signed [E-1:0] wi,
  input  logic signed [E-1:0] wg,
  input  logic signed [E-1:0] wf,
  input  logic signed [E-1:0] wo,
  input  logic signed [E-1:0] c_prev,
  output logic signed [E-1:0] c_new,
  output logic signed [E-1:0] h_new
);
  import lstm_pkg::*;

  localparam int W = 2 * E;

  logic signed [E-1:0] i, g, f, o, ct;
  logic signed [W-1:0] fc, ig, oh;
  logic signed [E:0]   sum;

  assign i = E'(hsig(int'(wi), F));
  assign f = E'(hsig(int'(wf), F));
  assign o = E'(hsig(int'(wo), F));
  assign g = E'(htanh(int'(wg), F));

  assign fc  = W'(f) * W'(c_prev);
  assign ig  = W'(i) * W'(g);
  assign sum = (E+1)'(fc >>> F) + (E+1)'(ig >>> F);

`ifdef LSTM_SAT_EN
  always_comb begin
    c_new = E'(sum);
    if (sum[E] != sum[E-1])
      c_new = sum[E] ? {1'b1, {(E-1){1'b0}}}
                     : {1'b0, {(E-1){1'b1}}};
  end
`else
  assign c_new = E'(sum);
`endif

  // htanh(c) and o are both bounded by ONE, so h never overflows E bits
  assign ct    = E'(htanh(int'(c_new), F));
  assign oh    = W'(o) * W'(ct);
  assign h_new = E'(oh >>> F);

endmodule

// File: rtl/lstm_cell_seq.sv
// Sequential LSTM cell: one element per cycle, serial h read-out.
// Optional macro LSTM_SAT_EN selects saturating cell-state reduction.
module lstm_cell_seq #(
  parameter int FEATURES     = 4,
  parameter int ELEMENT_BITS = 8,
  parameter int FRAC_BITS    = 6
) (
  input  logic                           sys_clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [FEATURES*ELEMENT_BITS-1:0] wi_xt,
  input  logic [FEATURES*ELEMENT_BITS-1:0] wg_xt,
  input  logic [FEATURES*ELEMENT_BITS-1:0] wf_xt,
  input  logic [FEATURES*ELEMENT_BITS-1:0] wo_xt,
  input  logic                           read_output,
  output logic [ELEMENT_BITS-1:0]        h_curr_ser,
  output logic                           h_ser_valid,
  output logic                           done_wr,
  output logic                           busy
);
  import lstm_pkg::*;

  localparam int E  = ELEMENT_BITS;
  localparam int CW = (FEATURES > 1) ? $clog2(FEATURES) : 1;

  typedef logic [FEATURES-1:0][E-1:0] vec_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  vec_t wi_q, wg_q, wf_q, wo_q, c_q, h_q;
  logic signed [E-1:0] c_new, h_new;
  logic [E-1:0] h_hold;
  logic last, latch, c_we;

  assign last = (cnt == CW'(FEATURES - 1));

  lstm_elem_unit #(
    .E (E),
    .F (FRAC_BITS)
  ) u_elem (
    .wi     (wi_q[cnt]),
    .wg     (wg_q[cnt]),
    .wf     (wf_q[cnt]),
    .wo     (wo_q[cnt]),
    .c_prev (c_q[cnt]),
    .c_new  (c_new),
    .h_new  (h_new)
  );

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    in_ready    = 1'b0;
    busy        = 1'b1;
    done_wr     = 1'b0;
    h_ser_valid = 1'b0;
    latch       = 1'b0;
    c_we        = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          latch    = 1'b1;
          cnt_nx   = '0;
          state_nx = CALC;
        end else if (read_output) begin
          cnt_nx   = '0;
          state_nx = SER;
        end
      end
      CALC: begin
        c_we = 1'b1;
        if (last) state_nx = DONE;
        else      cnt_nx   = cnt + 1'b1;
      end
      DONE: begin
        done_wr  = 1'b1;
        state_nx = IDLE;
      end
      SER: begin
        h_ser_valid = 1'b1;
        if (last) state_nx = IDLE;
        else      cnt_nx   = cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    h_curr_ser = h_ser_valid ? h_q[cnt] : h_hold;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      wi_q   <= '0;
      wg_q   <= '0;
      wf_q   <= '0;
      wo_q   <= '0;
      c_q    <= '0;
      h_q    <= '0;
      h_hold <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (latch) begin
        wi_q <= wi_xt;
        wg_q <= wg_xt;
        wf_q <= wf_xt;
        wo_q <= wo_xt;
      end
      if (c_we) begin
        c_q[cnt] <= c_new;
        h_q[cnt] <= h_new;
      end
      if (h_ser_valid) h_hold <= h_q[cnt];
    end
  end

endmodule
